// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and sizing helper for the sync FIFO controller and its RAM
package sync_fifo_pkg;
  typedef enum logic {OUT_EMPTY, OUT_VALID} out_state_e;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single write port, combinational read port storage cleared by either reset
module sync_fifo_ram import sync_fifo_pkg::*; #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem_q [fifo_depth(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] mem_d [fifo_depth(ADDR_WIDTH)];
  always_comb begin
    mem_d = srst ? '{default: '0} : mem_q;
    mem_d[wr_addr] = (wr_en & !srst) ? wr_data : mem_d[wr_addr];
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: valid/ready FIFO with RAM storage plus a registered first-word-fall-through output stage
module sync_fifo_ctrl import sync_fifo_pkg::*; #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW = ADDR_WIDTH + 1;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d, rd_data;
  logic s_ready_q, s_ready_d, almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  logic push, load;
  out_state_e state_q, state_d;
  sync_fifo_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .wr_en(push), .wr_addr(wr_ptr_q[ADDR_WIDTH-1:0]), .wr_data(s_data),
    .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]), .rd_data(rd_data)
  );
  // load uses the registered RAM count, so a word is never loadable on the edge it is written
  always_comb begin
    push = s_valid & s_ready_q;
    load = (ram_cnt_q != '0) & ((state_q == OUT_EMPTY) | m_ready);
    wr_ptr_d = srst ? '0 : wr_ptr_q + CW'(push);
    rd_ptr_d = srst ? '0 : rd_ptr_q + CW'(load);
    ram_cnt_d = srst ? '0 : ram_cnt_q + CW'(push) - CW'(load);
    state_d = srst ? OUT_EMPTY : load ? OUT_VALID : m_ready ? OUT_EMPTY : state_q;
    m_data_d = srst ? '0 : load ? rd_data : m_data_q;
    count_d = ram_cnt_d + CW'(state_d == OUT_VALID);
    s_ready_d = !srst & (ram_cnt_d < CW'(DEPTH));
    almost_full_d = count_d >= CW'(AFULL_THRESH);
    almost_empty_d = count_d <= CW'(AEMPTY_THRESH);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ram_cnt_q <= '0;
      count_q <= '0;
      state_q <= OUT_EMPTY;
      m_data_q <= '0;
      s_ready_q <= 1'b0;
      almost_full_q <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q <= count_d;
      state_q <= state_d;
      m_data_q <= m_data_d;
      s_ready_q <= s_ready_d;
      almost_full_q <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  assign s_ready = s_ready_q;
  assign m_valid = state_q == OUT_VALID;
  assign m_data = m_data_q;
  assign count = count_q;
  assign almost_full = almost_full_q;
  assign almost_empty = almost_empty_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: queue-based reference model checked every cycle plus directed literal expectations
module tb_sync_fifo_ctrl;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic srst = 1'b0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, m_valid, almost_full, almost_empty;
  logic [15:0] m_data;
  logic [4:0] count;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] ram_m[$];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  bit hv = 0, sr = 0, stall = 0, m_push, m_load;
  logic [15:0] hd = '0, prev_hd = '0;
  sync_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask
  // Model: contents queue behind a one-word head register; a word pushed this edge is only loadable next edge
  initial forever begin
    @(posedge aclk or negedge aresetn);
    if (!aresetn || srst) begin
      ram_m.delete();
      hv = 0; hd = '0; sr = 0; stall = 0;
    end else begin
      stall = hv && !m_ready;
      prev_hd = hd;
      m_push = s_valid && sr;
      m_load = ram_m.size() != 0 && (!hv || m_ready);
      if (m_load) begin hd = ram_m.pop_front(); hv = 1; end
      else if (m_ready) hv = 0;
      if (m_push) ram_m.push_back(s_data);
      sr = ram_m.size() < 16;
    end
  end
  initial forever begin
    int c;
    @(negedge aclk);
    c = ram_m.size() + int'(hv);
    chk("s_ready", s_ready, sr);
    chk("m_valid", m_valid, hv);
    chk("count", count, c);
    chk("m_data", m_data, hd);
    chk("almost_full", almost_full, c >= 14);
    chk("almost_empty", almost_empty, c <= 2);
    if (stall && aresetn) chk("stable", m_data, prev_hd);
  end
  initial forever begin
    @(negedge aclk);
    if (aresetn && !srst && m_valid && m_ready) got.push_back(m_data);
  end
  task automatic drain(input int n);
    m_ready = 1;
    for (int k = 0; k < 100 && got.size() < n; k++) cyc();
    m_ready = 0;
    chk("drain_size", got.size(), n);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    #1 aresetn = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("rel_s_ready", s_ready, 1);
    cyc();
    s_valid = 1; s_data = 16'hA5A5; m_ready = 1;
    cyc();
    s_valid = 0;
    @(negedge aclk);
    chk("lat_count_n", count, 1);
    chk("lat_mvalid_n", m_valid, 0);
    cyc();
    @(negedge aclk);
    chk("lat_mvalid", m_valid, 1);
    chk("lat_mdata", m_data, 16'hA5A5);
    chk("lat_count", count, 1);
    cyc();
    @(negedge aclk);
    chk("lat_pop_count", count, 0);
    cyc();
    m_ready = 0;
    got.delete();
    for (int i = 0; i < 17; i++) begin
      s_valid = 1; s_data = 16'(i);
      cyc();
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, i >= 13);
    end
    s_valid = 0;
    @(negedge aclk);
    chk("full_count", count, 17);
    chk("full_s_ready", s_ready, 0);
    cyc();
    drain(17);
    for (int i = 0; i < 17 && i < got.size(); i++) chk("fill_order", got[i], i);
    got.delete();
    s_valid = 1; m_ready = 1;
    for (int i = 0; i < 40; i++) begin
      s_data = 16'h100 + 16'(i);
      cyc();
      chk("wrap_count", count <= 2, 1);
    end
    s_valid = 0;
    drain(40);
    for (int i = 0; i < 40 && i < got.size(); i++) chk("wrap_order", got[i], 16'h100 + i);
    got.delete(); exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      m_ready = (i % 2) == 0;
      s_valid = 1'($urandom_range(0, 1));
      s_data = 16'($urandom);
      if (s_valid && s_ready) exp_q.push_back(s_data);
      cyc();
    end
    s_valid = 0;
    drain(exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("bp_order", got[i], exp_q[i]);
    for (int i = 0; i < 9; i++) begin
      s_valid = 1; s_data = 16'h200 + 16'(i);
      cyc();
    end
    s_valid = 0;
    @(negedge aclk);
    chk("pre_srst_count", count, 9);
    cyc();
    srst = 1;
    cyc();
    srst = 0;
    @(negedge aclk);
    chk("srst_count", count, 0);
    chk("srst_m_valid", m_valid, 0);
    chk("srst_s_ready", s_ready, 0);
    cyc();
    chk("srst_s_ready_rel", s_ready, 1);
    got.delete();
    s_valid = 1; s_data = 16'h1234;
    cyc();
    s_valid = 0;
    drain(1);
    if (got.size() > 0) chk("srst_first", got[0], 16'h1234);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 16'h300 + 16'(i);
      cyc();
    end
    #1 aresetn = 0;
    s_valid = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_s_ready", s_ready, 0);
    cyc();
    aresetn = 1;
    cyc();
    chk("arst_s_ready_rel", s_ready, 1);
    got.delete();
    s_valid = 1; s_data = 16'h1234;
    cyc();
    s_valid = 0;
    drain(1);
    if (got.size() > 0) chk("arst_first", got[0], 16'h1234);
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
